// File: rtl/sdram_fifo_ctrl_pkg.sv
// Shared types and constants for the SDRAM FIFO request generator.
package sdram_fifo_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrBurst,
    StRdReq,
    StRdBurst
  } ctrl_state_e;

  localparam int unsigned LenW = 10;

endpackage

// File: rtl/sdram_sync_fifo.sv
// Single-clock show-ahead FIFO with synchronous flush; head is valid whenever !empty.
module sdram_sync_fifo #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 1024,
  localparam int unsigned PtrW      = $clog2(FIFO_DEPTH),
  localparam int unsigned CntW      = PtrW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [CntW-1:0]   count
);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   cnt_q;
  logic              do_push, do_pop;

  assign full    = (cnt_q == CntW'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CntW'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/sdram_fifo_ctrl.sv
// Burst request generator: drains the write FIFO and fills the read FIFO in fixed-length
// SDRAM bursts over wrapping address regions.
module sdram_fifo_ctrl
  import sdram_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned FIFO_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_full,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_empty,
  input  logic [ADDR_W-1:0] wr_min_addr,
  input  logic [ADDR_W-1:0] wr_max_addr,
  input  logic [ADDR_W-1:0] rd_min_addr,
  input  logic [ADDR_W-1:0] rd_max_addr,
  input  logic [9:0]        wr_len,
  input  logic [9:0]        rd_len,
  input  logic              wr_load,
  input  logic              rd_load,
  input  logic              read_valid,
  input  logic              sdram_init_done,
  output logic              sdram_wr_req,
  input  logic              sdram_wr_ack,
  output logic [ADDR_W-1:0] sdram_wr_addr,
  output logic [9:0]        sdram_wr_burst,
  output logic [DATA_W-1:0] sdram_din,
  output logic              sdram_rd_req,
  input  logic              sdram_rd_ack,
  output logic [ADDR_W-1:0] sdram_rd_addr,
  output logic [9:0]        sdram_rd_burst,
  input  logic [DATA_W-1:0] sdram_dout
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned NxtW  = ADDR_W + 1;

  ctrl_state_e       state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [LenW-1:0]   wr_len_q, wr_len_d, rd_len_q, rd_len_d;
  logic              wr_req_q, rd_req_q;
  logic              wr_ack_q, rd_ack_q;
  logic              wr_load_pend_q, wr_load_pend_d, rd_load_pend_q, rd_load_pend_d;
  logic              wr_flush, rd_flush;
  logic [CNT_W-1:0]  wr_cnt, rd_cnt, rd_space;
  logic              wr_empty, rd_full;
  logic [NxtW-1:0]   wr_nxt, rd_nxt;

  sdram_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (wr_flush),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (sdram_wr_ack),
    .head      (sdram_din),
    .full      (wr_full),
    .empty     (wr_empty),
    .count     (wr_cnt)
  );

  sdram_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_rd_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (rd_flush),
    .push      (sdram_rd_ack),
    .push_data (sdram_dout),
    .pop       (rd_en),
    .head      (rd_data),
    .full      (rd_full),
    .empty     (rd_empty),
    .count     (rd_cnt)
  );

  assign rd_space = CNT_W'(FIFO_DEPTH) - rd_cnt;
  assign wr_nxt   = {1'b0, wr_addr_q} + NxtW'(wr_len_q);
  assign rd_nxt   = {1'b0, rd_addr_q} + NxtW'(rd_len_q);

  always_comb begin
    state_d        = state_q;
    wr_addr_d      = wr_addr_q;
    rd_addr_d      = rd_addr_q;
    wr_len_d       = wr_len_q;
    rd_len_d       = rd_len_q;
    wr_load_pend_d = wr_load_pend_q | wr_load;
    rd_load_pend_d = rd_load_pend_q | rd_load;
    wr_flush       = 1'b0;
    rd_flush       = 1'b0;

    unique case (state_q)
      StIdle: begin
        wr_len_d = wr_len;
        rd_len_d = rd_len;
        // Loads take a whole IDLE cycle so no request races a flush.
        if (wr_load_pend_q || rd_load_pend_q) begin
          if (wr_load_pend_q) begin
            wr_flush       = 1'b1;
            wr_addr_d      = wr_min_addr;
            wr_load_pend_d = wr_load;
          end
          if (rd_load_pend_q) begin
            rd_flush       = 1'b1;
            rd_addr_d      = rd_min_addr;
            rd_load_pend_d = rd_load;
          end
        end else if (sdram_init_done && !wr_empty && wr_cnt >= CNT_W'(wr_len)) begin
          state_d = StWrReq;
        end else if (sdram_init_done && read_valid && !rd_full
                     && rd_space >= CNT_W'(rd_len)) begin
          state_d = StRdReq;
        end
      end
      StWrReq: if (sdram_wr_ack) state_d = StWrBurst;
      StWrBurst: begin
        if (!sdram_wr_ack && wr_ack_q) begin
          wr_addr_d = (wr_nxt >= {1'b0, wr_max_addr}) ? wr_min_addr : wr_nxt[ADDR_W-1:0];
          state_d   = StIdle;
        end
      end
      StRdReq: if (sdram_rd_ack) state_d = StRdBurst;
      StRdBurst: begin
        if (!sdram_rd_ack && rd_ack_q) begin
          rd_addr_d = (rd_nxt >= {1'b0, rd_max_addr}) ? rd_min_addr : rd_nxt[ADDR_W-1:0];
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      wr_addr_q      <= '0;
      rd_addr_q      <= '0;
      wr_len_q       <= '0;
      rd_len_q       <= '0;
      wr_req_q       <= 1'b0;
      rd_req_q       <= 1'b0;
      wr_ack_q       <= 1'b0;
      rd_ack_q       <= 1'b0;
      wr_load_pend_q <= 1'b1;
      rd_load_pend_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      wr_addr_q      <= wr_addr_d;
      rd_addr_q      <= rd_addr_d;
      wr_len_q       <= wr_len_d;
      rd_len_q       <= rd_len_d;
      wr_req_q       <= (state_d == StWrReq);
      rd_req_q       <= (state_d == StRdReq);
      wr_ack_q       <= sdram_wr_ack;
      rd_ack_q       <= sdram_rd_ack;
      wr_load_pend_q <= wr_load_pend_d;
      rd_load_pend_q <= rd_load_pend_d;
    end
  end

  assign sdram_wr_req   = wr_req_q;
  assign sdram_rd_req   = rd_req_q;
  assign sdram_wr_addr  = wr_addr_q;
  assign sdram_rd_addr  = rd_addr_q;
  assign sdram_wr_burst = wr_len_q;
  assign sdram_rd_burst = rd_len_q;

endmodule

// File: tb/tb_sdram_fifo_ctrl.sv
// Scoreboard bench for sdram_fifo_ctrl with a simple SDRAM controller model.
module tb_sdram_fifo_ctrl;

  localparam int DW = 16;
  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en, rd_en, wr_full, rd_empty;
  logic [DW-1:0] wr_data, rd_data, sdram_din, sdram_dout;
  logic [AW-1:0] wr_min_addr, wr_max_addr, rd_min_addr, rd_max_addr;
  logic [AW-1:0] sdram_wr_addr, sdram_rd_addr;
  logic [9:0]    wr_len, rd_len, sdram_wr_burst, sdram_rd_burst;
  logic          wr_load, rd_load, read_valid, sdram_init_done;
  logic          sdram_wr_req, sdram_wr_ack, sdram_rd_req, sdram_rd_ack;

  always #5 clk = ~clk;

  sdram_fifo_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .wr_en           (wr_en),
    .wr_data         (wr_data),
    .wr_full         (wr_full),
    .rd_en           (rd_en),
    .rd_data         (rd_data),
    .rd_empty        (rd_empty),
    .wr_min_addr     (wr_min_addr),
    .wr_max_addr     (wr_max_addr),
    .rd_min_addr     (rd_min_addr),
    .rd_max_addr     (rd_max_addr),
    .wr_len          (wr_len),
    .rd_len          (rd_len),
    .wr_load         (wr_load),
    .rd_load         (rd_load),
    .read_valid      (read_valid),
    .sdram_init_done (sdram_init_done),
    .sdram_wr_req    (sdram_wr_req),
    .sdram_wr_ack    (sdram_wr_ack),
    .sdram_wr_addr   (sdram_wr_addr),
    .sdram_wr_burst  (sdram_wr_burst),
    .sdram_din       (sdram_din),
    .sdram_rd_req    (sdram_rd_req),
    .sdram_rd_ack    (sdram_rd_ack),
    .sdram_rd_addr   (sdram_rd_addr),
    .sdram_rd_burst  (sdram_rd_burst),
    .sdram_dout      (sdram_dout)
  );

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] exp_wr_addr[$];
  logic [AW-1:0] exp_rd_addr[$];
  logic [DW-1:0] exp_din[$];
  logic [DW-1:0] exp_rd[$];
  logic [DW-1:0] rd_src[$];
  int            req_order[$];   // 0 = write request, 1 = read request
  bit            overlap = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: got an event with nothing expected", name);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [DW-1:0] v);
    wr_en   = 1'b1;
    wr_data = v;
    step(1);
    wr_en   = 1'b0;
  endtask

  task automatic wait_wr_done(input string name);
    int n = 0;
    while ((exp_din.size() != 0 || exp_wr_addr.size() != 0 || sdram_wr_req || sdram_wr_ack)
           && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n < 600), 32'd1);
    step(3);
  endtask

  task automatic wait_rd_done(input string name);
    int n = 0;
    while ((rd_src.size() != 0 || exp_rd_addr.size() != 0 || sdram_rd_req || sdram_rd_ack)
           && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n < 600), 32'd1);
    step(3);
  endtask

  task automatic wait_rd_req(input string name);
    int n = 0;
    while (!sdram_rd_req && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n < 600), 32'd1);
    step(1);
  endtask

  // SDRAM controller model: acks a pending request for the presented burst length.
  initial begin : ctrl_model
    int n;
    sdram_wr_ack = 1'b0;
    sdram_rd_ack = 1'b0;
    sdram_dout   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (sdram_wr_req) begin
        n = int'(sdram_wr_burst);
        sdram_wr_ack = 1'b1;
        step(n);
        sdram_wr_ack = 1'b0;
      end else if (sdram_rd_req) begin
        n = int'(sdram_rd_burst);
        sdram_rd_ack = 1'b1;
        for (int i = 0; i < n; i++) begin
          sdram_dout = (rd_src.size() != 0) ? rd_src.pop_front() : '0;
          step(1);
        end
        sdram_rd_ack = 1'b0;
      end
    end
  end

  // Monitor: compares every DUT-presented output against the scoreboard queues.
  initial begin : monitor
    logic prev_wr_req = 1'b0;
    logic prev_rd_req = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (sdram_wr_req && sdram_rd_req) overlap = 1'b1;
        if (sdram_wr_req && !prev_wr_req) begin
          req_order.push_back(0);
          if (exp_wr_addr.size() == 0) unexpected("wr_req");
          else begin
            chk("wr_addr", 32'(sdram_wr_addr), 32'(exp_wr_addr.pop_front()));
            chk("wr_burst", 32'(sdram_wr_burst), 32'(wr_len));
          end
        end
        if (sdram_rd_req && !prev_rd_req) begin
          req_order.push_back(1);
          if (exp_rd_addr.size() == 0) unexpected("rd_req");
          else begin
            chk("rd_addr", 32'(sdram_rd_addr), 32'(exp_rd_addr.pop_front()));
            chk("rd_burst", 32'(sdram_rd_burst), 32'(rd_len));
          end
        end
        if (sdram_wr_ack) begin
          if (exp_din.size() == 0) unexpected("sdram_din");
          else chk("sdram_din", 32'(sdram_din), 32'(exp_din.pop_front()));
        end
        if (rd_en && !rd_empty) begin
          if (exp_rd.size() == 0) unexpected("rd_data");
          else chk("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
        end
      end
      prev_wr_req = sdram_wr_req;
      prev_rd_req = sdram_rd_req;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin : stimulus
    int base;
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
    wr_min_addr = 24'h000100; wr_max_addr = 24'h000110;
    rd_min_addr = 24'h000200; rd_max_addr = 24'h000400;
    wr_len = 10'd8; rd_len = 10'd4;
    wr_load = 1'b0; rd_load = 1'b0; read_valid = 1'b0; sdram_init_done = 1'b0;

    // 1: reset values, then pending loads apply the min addresses.
    step(3);
    chk("rst_wr_req", 32'(sdram_wr_req), 32'd0);
    chk("rst_rd_empty", 32'(rd_empty), 32'd1);
    chk("rst_wr_addr", 32'(sdram_wr_addr), 32'd0);
    rst = 1'b0;
    step(3);
    @(negedge clk);
    chk("idle_wr_req", 32'(sdram_wr_req), 32'd0);
    chk("idle_rd_req", 32'(sdram_rd_req), 32'd0);
    chk("idle_rd_empty", 32'(rd_empty), 32'd1);
    chk("idle_wr_full", 32'(wr_full), 32'd0);
    chk("load_wr_addr", 32'(sdram_wr_addr), 32'h100);
    chk("load_rd_addr", 32'(sdram_rd_addr), 32'h200);

    // 2: one write burst of 0..7.
    step(1);
    sdram_init_done = 1'b1;
    exp_wr_addr.push_back(24'h100);
    for (int i = 0; i < 8; i++) exp_din.push_back(16'(i));
    for (int i = 0; i < 8; i++) write_word(16'(i));
    wait_wr_done("t2_timeout");
    @(negedge clk);
    chk("t2_wr_addr", 32'(sdram_wr_addr), 32'h108);
    chk("t2_req_count", 32'(req_order.size()), 32'd1);

    // 3: reload, then three bursts wrap 0x100, 0x108, 0x100.
    step(1);
    wr_load = 1'b1; step(1); wr_load = 1'b0;
    step(3);
    @(negedge clk);
    chk("t3_reload_addr", 32'(sdram_wr_addr), 32'h100);
    step(1);
    exp_wr_addr.push_back(24'h100);
    exp_wr_addr.push_back(24'h108);
    exp_wr_addr.push_back(24'h100);
    for (int i = 0; i < 24; i++) exp_din.push_back(16'(16'h10 + i));
    for (int i = 0; i < 24; i++) write_word(16'(16'h10 + i));
    wait_wr_done("t3_timeout");
    @(negedge clk);
    chk("t3_wr_addr", 32'(sdram_wr_addr), 32'h108);
    chk("t3_req_count", 32'(req_order.size()), 32'd4);

    // 4: one read burst A..D, drained by the user side.
    step(1);
    exp_rd_addr.push_back(24'h200);
    for (int i = 0; i < 4; i++) begin
      rd_src.push_back(16'(16'hA0A0 + i));
      exp_rd.push_back(16'(16'hA0A0 + i));
    end
    read_valid = 1'b1;
    wait_rd_req("t4_req_timeout");
    read_valid = 1'b0;
    wait_rd_done("t4_timeout");
    @(negedge clk);
    chk("t4_rd_empty", 32'(rd_empty), 32'd0);
    chk("t4_rd_addr", 32'(sdram_rd_addr), 32'h204);
    step(1);
    rd_en = 1'b1; step(4); rd_en = 1'b0;
    @(negedge clk);
    chk("t4_rd_empty_after", 32'(rd_empty), 32'd1);

    // 5: write and read both eligible at once; write goes first.
    step(1);
    sdram_init_done = 1'b0;
    exp_wr_addr.push_back(24'h108);
    for (int i = 0; i < 8; i++) exp_din.push_back(16'(16'h40 + i));
    for (int i = 0; i < 8; i++) write_word(16'(16'h40 + i));
    exp_rd_addr.push_back(24'h204);
    for (int i = 0; i < 4; i++) begin
      rd_src.push_back(16'(16'hB0B0 + i));
      exp_rd.push_back(16'(16'hB0B0 + i));
    end
    read_valid = 1'b1;
    step(2);
    base = req_order.size();
    sdram_init_done = 1'b1;
    wait_rd_req("t5_req_timeout");
    read_valid = 1'b0;
    wait_wr_done("t5_wr_timeout");
    wait_rd_done("t5_rd_timeout");
    if (req_order.size() >= base + 2) begin
      chk("t5_first_is_wr", 32'(req_order[base]), 32'd0);
      chk("t5_second_is_rd", 32'(req_order[base+1]), 32'd1);
    end else begin
      chk("t5_req_count", 32'(req_order.size()), 32'(base + 2));
    end
    rd_en = 1'b1; step(4); rd_en = 1'b0;
    @(negedge clk);
    chk("t5_wr_addr", 32'(sdram_wr_addr), 32'h100);
    chk("t5_rd_addr", 32'(sdram_rd_addr), 32'h208);

    // 6: wr_load during a burst; burst finishes, then flush drops the 9 leftover words.
    step(1);
    sdram_init_done = 1'b0;
    exp_wr_addr.push_back(24'h100);
    for (int i = 0; i < 8; i++) exp_din.push_back(16'(16'h60 + i));
    for (int i = 0; i < 17; i++) write_word(16'(16'h60 + i));
    base = req_order.size();
    sdram_init_done = 1'b1;
    begin
      int n = 0;
      while (!sdram_wr_ack && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("t6_ack_timeout", 32'(n < 100), 32'd1);
    end
    step(2);
    wr_load = 1'b1; step(1); wr_load = 1'b0;
    wait_wr_done("t6_timeout");
    @(negedge clk);
    chk("t6_wr_addr", 32'(sdram_wr_addr), 32'h100);
    chk("t6_wr_full", 32'(wr_full), 32'd0);
    step(20);
    chk("t6_req_count", 32'(req_order.size()), 32'(base + 1));

    // 7: write FIFO full boundary, then flushed by a load.
    sdram_init_done = 1'b0;
    for (int i = 0; i < 1023; i++) write_word(16'(i));
    @(negedge clk);
    chk("t7_not_full", 32'(wr_full), 32'd0);
    step(1);
    write_word(16'hFFFF);
    @(negedge clk);
    chk("t7_full", 32'(wr_full), 32'd1);
    step(1);
    write_word(16'hEEEE);
    wr_load = 1'b1; step(1); wr_load = 1'b0;
    step(3);
    @(negedge clk);
    chk("t7_flushed", 32'(wr_full), 32'd0);
    base = req_order.size();
    step(1);
    sdram_init_done = 1'b1;
    step(20);
    chk("t7_no_req", 32'(req_order.size()), 32'(base));

    chk("req_overlap", 32'(overlap), 32'd0);
    chk("leftover", 32'(exp_din.size() + exp_rd.size() + exp_wr_addr.size()
                        + exp_rd_addr.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
